// File: rtl/sub_seq.sv
// Multi-precision subtract sequencer: computes a - b - bin over N byte-wide
// passes through a single shared 8-bit subtractor, LSB first, with the
// borrow chained through a register between passes.

// 8-bit subtract slice: s = (a - b - ci) mod 256, co = 1 on borrow.
module sub8 (
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       ci,
    output logic [7:0] s,
    output logic       co
);
    logic [8:0] diff;

    // Ninth bit of the zero-extended difference is the borrow-out.
    assign diff = {1'b0, a} - {1'b0, b} - {8'd0, ci};
    assign s    = diff[7:0];
    assign co   = diff[8];
endmodule

module sub_seq #(
    parameter int unsigned N = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [8*N-1:0] a,
    input  logic [8*N-1:0] b,
    input  logic           bin,
    output logic           busy,
    output logic           done,
    output logic [8*N-1:0] s,
    output logic           bout,
    output logic           zero
);
    localparam int unsigned IW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [IW-1:0]        idx_q, idx_d;
    logic [N-1:0][7:0]    a_q, a_d;
    logic [N-1:0][7:0]    b_q, b_d;
    logic [N-1:0][7:0]    s_q, s_d;
    logic                 brw_q, brw_d;
    logic                 nz_q, nz_d;
    logic                 bout_q, bout_d;
    logic                 zero_q, zero_d;

    logic [7:0]           s8;
    logic                 co8;

    sub8 u_sub8 (
        .a  (a_q[idx_q]),
        .b  (b_q[idx_q]),
        .ci (brw_q),
        .s  (s8),
        .co (co8)
    );

    // State and datapath registers; reset abandons any operation in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            s_q     <= '0;
            brw_q   <= 1'b0;
            nz_q    <= 1'b0;
            bout_q  <= 1'b0;
            zero_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            a_q     <= a_d;
            b_q     <= b_d;
            s_q     <= s_d;
            brw_q   <= brw_d;
            nz_q    <= nz_d;
            bout_q  <= bout_d;
            zero_q  <= zero_d;
        end
    end

    // Next-state: accept in IDLE, one byte per RUN edge, single DONE cycle.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        a_d     = a_q;
        b_d     = b_q;
        s_d     = s_q;
        brw_d   = brw_q;
        nz_d    = nz_q;
        bout_d  = bout_q;
        zero_d  = zero_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                    a_d     = a;
                    b_d     = b;
                    brw_d   = bin;
                    idx_d   = '0;
                    nz_d    = 1'b0;
                end
            end
            RUN: begin
                s_d[idx_q] = s8;
                brw_d      = co8;
                nz_d       = nz_q | (s8 != 8'd0);
                if (idx_q == IW'(N - 1)) begin
                    // Last byte: idx is left in place rather than wrapped.
                    state_d = DONE;
                    bout_d  = co8;
                    zero_d  = ~(nz_q | (s8 != 8'd0));
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign busy = (state_q != IDLE);
    assign done = (state_q == DONE);
    assign s    = s_q;
    assign bout = bout_q;
    assign zero = zero_q;
endmodule

// File: tb/tb_sub_seq.sv
// Scoreboard bench for sub_seq (N=4): stimulus pushes expected results,
// a negedge monitor pops and compares on every done pulse.
module tb_sub_seq;
    localparam int unsigned N = 4;
    localparam int unsigned W = 8 * N;

    typedef struct {
        logic [W-1:0] s;
        logic         bout;
        logic         zero;
    } exp_t;

    logic         clk;
    logic         rst;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         bin;
    logic         busy;
    logic         done;
    logic [W-1:0] s;
    logic         bout;
    logic         zero;

    exp_t q[$];
    int   pass_cnt;
    int   total_cnt;
    int   done_cnt;
    logic hold_b;
    logic hold_z;
    time  last_done_t;
    time  prev_done_t;

    sub_seq #(.N(N)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .bin   (bin),
        .busy  (busy),
        .done  (done),
        .s     (s),
        .bout  (bout),
        .zero  (zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic push(input logic [W-1:0] es, input logic eb, input logic ez);
        exp_t e;
        e.s    = es;
        e.bout = eb;
        e.zero = ez;
        q.push_back(e);
    endtask

    // Monitor: compare each done against the scoreboard; between dones the
    // borrow-out and zero flags must hold the last completed values.
    always @(negedge clk) begin
        if (rst) begin
            hold_b = 1'b0;
            hold_z = 1'b0;
        end else if (done) begin
            done_cnt++;
            prev_done_t = last_done_t;
            last_done_t = $time;
            if (q.size() == 0) begin
                check("unexpected_done", 64'd1, 64'd0);
            end else begin
                exp_t e;
                e = q.pop_front();
                check("result_s", 64'(s), 64'(e.s));
                check("result_bout", 64'(bout), 64'(e.bout));
                check("result_zero", 64'(zero), 64'(e.zero));
                hold_b = e.bout;
                hold_z = e.zero;
            end
        end else begin
            check("hold_flags", {62'd0, bout, zero}, {62'd0, hold_b, hold_z});
        end
    end

    // One isolated operation with timing checks on busy and done.
    task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_,
                          input logic tbin, input logic [W-1:0] es,
                          input logic eb, input logic ez);
        int busy_cyc;
        int done_pos;
        @(negedge clk);
        a = ta; b = tb_; bin = tbin; start = 1'b1;
        push(es, eb, ez);
        @(posedge clk);
        #1;
        start = 1'b0;
        // Operands scrambled after acceptance must not matter.
        a = ~ta; b = W'($urandom); bin = ~tbin;
        busy_cyc = 0;
        done_pos = 0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (busy) busy_cyc++;
            if (done && done_pos == 0) done_pos = i;
            if (!busy) break;
        end
        check("busy_cycles", 64'(busy_cyc), 64'd5);
        check("done_position", 64'(done_pos), 64'd5);
    endtask

    task automatic wait_done_bounded(input int limit);
        int n0;
        n0 = done_cnt;
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            if (done_cnt != n0) return;
        end
        check("done_timeout", 64'd1, 64'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int n0;
        pass_cnt = 0; total_cnt = 0; done_cnt = 0;
        hold_b = 1'b0; hold_z = 1'b0;
        last_done_t = 0; prev_done_t = 0;
        rst = 1'b1; start = 1'b0; a = '0; b = '0; bin = 1'b0;
        #12;
        check("reset_outputs", {27'd0, busy, done, bout, zero, s}, 64'd0);
        @(negedge clk);
        #2 rst = 1'b0;

        // Basic, full ripple, zero, borrow-in.
        run_op(32'h0000_0005, 32'h0000_0003, 1'b0, 32'h0000_0002, 1'b0, 1'b0);
        run_op(32'h0000_0000, 32'h0000_0001, 1'b0, 32'hFFFF_FFFF, 1'b1, 1'b0);
        run_op(32'h1234_5678, 32'h1234_5678, 1'b0, 32'h0000_0000, 1'b0, 1'b1);
        run_op(32'h0000_0100, 32'h0000_0000, 1'b1, 32'h0000_00FF, 1'b0, 1'b0);

        // Start while busy: second request must be dropped.
        n0 = done_cnt;
        @(negedge clk);
        a = 32'h10; b = 32'h01; bin = 1'b0; start = 1'b1;
        push(32'h0000_000F, 1'b0, 1'b0);
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        a = 32'hFF; b = 32'hFF; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        wait_done_bounded(20);
        repeat (10) @(negedge clk);
        check("busy_start_single_done", 64'(done_cnt - n0), 64'd1);

        // Back-to-back with start held high.
        @(negedge clk);
        n0 = done_cnt;
        a = 32'h0000_0001; b = 32'h0000_0002; bin = 1'b0; start = 1'b1;
        push(32'hFFFF_FFFF, 1'b1, 1'b0);
        wait_done_bounded(20);
        a = 32'h8000_0000; b = 32'h7FFF_FFFF; bin = 1'b0;
        push(32'h0000_0001, 1'b0, 1'b0);
        wait_done_bounded(20);
        check("b2b_interval_1", 64'(last_done_t - prev_done_t), 64'd60);
        a = 32'hABCD_0000; b = 32'hABCD_0000; bin = 1'b0;
        push(32'h0000_0000, 1'b0, 1'b1);
        wait_done_bounded(20);
        check("b2b_interval_2", 64'(last_done_t - prev_done_t), 64'd60);
        a = 32'h0000_0000; b = 32'h0000_0000; bin = 1'b1;
        push(32'hFFFF_FFFF, 1'b1, 1'b0);
        wait_done_bounded(20);
        check("b2b_interval_3", 64'(last_done_t - prev_done_t), 64'd60);
        start = 1'b0;
        repeat (8) @(negedge clk);
        check("b2b_done_count", 64'(done_cnt - n0), 64'd4);

        // Reset mid-RUN, after E2, with bout=1 left from the previous op.
        @(negedge clk);
        a = 32'h0000_0009; b = 32'h0000_0004; bin = 1'b0; start = 1'b1;
        push(32'h0000_0005, 1'b0, 1'b0);
        @(posedge clk);
        #1 start = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2 rst = 1'b1;
        q.delete();
        #1;
        check("midrun_reset_outputs", {27'd0, busy, done, bout, zero, s}, 64'd0);
        @(negedge clk);
        #2 rst = 1'b0;
        n0 = done_cnt;
        repeat (10) @(negedge clk);
        check("no_done_after_reset", 64'(done_cnt - n0), 64'd0);
        run_op(32'hDEAD_BEEF, 32'h1111_1111, 1'b0, 32'hCD9C_ADDE, 1'b0, 1'b0);

        repeat (3) @(negedge clk);
        check("scoreboard_empty", 64'(q.size()), 64'd0);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
